odyssey_video_timing: RTL and testbench

- Raster timing stage directly upstream of the per-object spot generators.
- Produces the free-running horizontal and vertical beam counters that every generator compares against its position and size inputs.
- Also produces sync and blank strobes for the video mixer and output scaler.
- Runs on the system clock and advances only on a pixel clock-enable. All outputs are registered and mutually aligned.

---
 rtl/odyssey_video_timing.sv | 91 +++++++++
 tb/tb_odyssey_video_timing.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/odyssey_video_timing.sv
// odyssey_video_timing: free-running raster counters with registered sync/blank/start strobes; ODYSSEY_VT_FIELD_EN adds an alternating-length field output
module odyssey_video_timing #(
    parameter int h_bitwidth   = 9,
    parameter int v_bitwidth   = 9,
    parameter int H_TOTAL      = 455,
    parameter int H_ACTIVE     = 360,
    parameter int H_SYNC_START = 380,
    parameter int H_SYNC_END   = 414,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_END   = 247
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce_pix,
    output logic [h_bitwidth-1:0] HORIZ,
    output logic [v_bitwidth-1:0] VERT,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  hblank,
    output logic                  vblank,
`ifdef ODYSSEY_VT_FIELD_EN
    output logic                  field,
`endif
    output logic                  line_start,
    output logic                  frame_start
);
    localparam logic [h_bitwidth-1:0] H_LAST = h_bitwidth'(H_TOTAL - 1);
    localparam logic [v_bitwidth-1:0] V_LAST = v_bitwidth'(V_TOTAL - 1);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
        $error("odyssey_video_timing: illegal horizontal timing parameters");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
        $error("odyssey_video_timing: illegal vertical timing parameters");
    end
    if (H_TOTAL > 2 ** h_bitwidth) begin : g_bad_hw
        $error("odyssey_video_timing: h_bitwidth too small for H_TOTAL");
    end

    logic                  h_wrap;
    logic                  v_wrap;
    logic [v_bitwidth-1:0] v_last;
    logic [h_bitwidth-1:0] h_nxt;
    logic [v_bitwidth-1:0] v_nxt;

    // next-state counters; decodes below use these so strobes align with HORIZ/VERT
    always_comb begin
`ifdef ODYSSEY_VT_FIELD_EN
        v_last = field ? v_bitwidth'(V_TOTAL) : V_LAST;
`else
        v_last = V_LAST;
`endif
        h_wrap = HORIZ == H_LAST;
        v_wrap = h_wrap && VERT == v_last;
        h_nxt  = !ce_pix ? HORIZ : h_wrap ? '0 : HORIZ + 1'b1;
        v_nxt  = !(ce_pix && h_wrap) ? VERT : v_wrap ? '0 : VERT + 1'b1;
    end

    // counters and decoded strobes share one register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HORIZ       <= '0;
            VERT        <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            HORIZ       <= h_nxt;
            VERT        <= v_nxt;
            hsync       <= 32'(h_nxt) >= H_SYNC_START && 32'(h_nxt) < H_SYNC_END;
            vsync       <= 32'(v_nxt) >= V_SYNC_START && 32'(v_nxt) < V_SYNC_END;
            hblank      <= 32'(h_nxt) >= H_ACTIVE;
            vblank      <= 32'(v_nxt) >= V_ACTIVE;
            line_start  <= ce_pix && h_wrap;
            frame_start <= ce_pix && v_wrap;
        end
    end

`ifdef ODYSSEY_VT_FIELD_EN
    // field flips at every frame wrap, alternating short and long frames
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) field <= 1'b0;
        else        field <= field ^ (ce_pix && v_wrap);
    end
`endif
endmodule

// File: tb/tb_odyssey_video_timing.sv
// tb_odyssey_video_timing: directed + random checks of odyssey_video_timing against a pixel-count reference model
module tb_odyssey_video_timing;
    localparam int HT  = 455;
    localparam int HA  = 360;
    localparam int HSS = 380;
    localparam int HSE = 414;
    localparam int VT  = 20;
    localparam int VA  = 14;
    localparam int VSS = 16;
    localparam int VSE = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [8:0] HORIZ;
    logic [8:0] VERT;
    logic       hsync, vsync, hblank, vblank, line_start, frame_start;
`ifdef ODYSSEY_VT_FIELD_EN
    logic       field;
`endif

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit pulsed = 0;

    odyssey_video_timing #(
        .h_bitwidth(9), .v_bitwidth(9),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix),
        .HORIZ(HORIZ), .VERT(VERT),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
`ifdef ODYSSEY_VT_FIELD_EN
        .field(field),
`endif
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // reference: raster position follows from the count of enabled pixels since reset
    function automatic int exp_h(input int cnt);
        return cnt % HT;
    endfunction

    function automatic int exp_line(input int cnt);
`ifdef ODYSSEY_VT_FIELD_EN
        return (cnt / HT) % (2 * VT + 1);
`else
        return (cnt / HT) % VT;
`endif
    endfunction

    function automatic int exp_v(input int cnt);
        return exp_line(cnt) >= VT ? exp_line(cnt) - VT : exp_line(cnt);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int h;
        int v;
        bit ls;
        h  = exp_h(n);
        v  = exp_v(n);
        ls = pulsed && h == 0;
        chk("HORIZ", 32'(HORIZ), 32'(h));
        chk("VERT", 32'(VERT), 32'(v));
        chk("hsync", 32'(hsync), 32'(h >= HSS && h < HSE));
        chk("vsync", 32'(vsync), 32'(v >= VSS && v < VSE));
        chk("hblank", 32'(hblank), 32'(h >= HA));
        chk("vblank", 32'(vblank), 32'(v >= VA));
        chk("line_start", 32'(line_start), 32'(ls));
        chk("frame_start", 32'(frame_start), 32'(ls && v == 0));
`ifdef ODYSSEY_VT_FIELD_EN
        chk("field", 32'(field), 32'(exp_line(n) >= VT));
`endif
    endtask

    task automatic step(input logic ce);
        ce_pix = ce;
        @(posedge clk);
        if (reset) begin
            if (ce) n++;
            pulsed = ce;
        end
        #1;
        check_all();
    endtask

    initial begin
        int hs_cnt, hb_cnt, ls_cnt, vs_cnt, vb_cnt, fs_cnt, ls_off, budget, vmax;
        reset  = 1'b0;
        ce_pix = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_all();

        reset = 1'b1;
        step(1'b1);
        chk("first_pixel", 32'(HORIZ), 32'd1);

        hs_cnt = 0; hb_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < HT - 1; i++) begin
            step(1'b1);
            hs_cnt += int'(hsync);
            hb_cnt += int'(hblank);
            ls_cnt += int'(line_start);
        end
        chk("line_wrap_h", 32'(HORIZ), 32'd0);
        chk("line_wrap_v", 32'(VERT), 32'd1);
        chk("hsync_len", 32'(hs_cnt), 32'(HSE - HSS));
        chk("hblank_len", 32'(hb_cnt), 32'(HT - HA));
        chk("line_start_cnt", 32'(ls_cnt), 32'd1);

        vs_cnt = 0; vb_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < HT * (VT - 1); i++) begin
            step(1'b1);
            vs_cnt += int'(vsync);
            vb_cnt += int'(vblank);
            fs_cnt += int'(frame_start);
        end
        chk("frame_wrap_v", 32'(VERT), 32'd0);
        chk("frame_start_now", 32'(frame_start), 32'd1);
        chk("vsync_len", 32'(vs_cnt), 32'((VSE - VSS) * HT));
        chk("vblank_len", 32'(vb_cnt), 32'((VT - VA) * HT));
        chk("frame_start_cnt", 32'(fs_cnt), 32'd1);

        ls_off = 0;
        for (int i = 0; i < 2 * HT + 4; i++) begin
            step(1'b1);
            step(1'b0);
            ls_off += int'(line_start);
        end
        chk("gated_line_start", 32'(ls_off), 32'd0);

        for (int i = 0; i < 4000; i++) step(($urandom % 4) != 0);

        budget = 0;
        while (!(exp_v(n) == 10 && exp_h(n) == 200) && budget < 3 * HT * (VT + 1)) begin
            step(1'b1);
            budget++;
        end
        chk("reach_mid_frame", 32'(HORIZ), 32'd200);
        #3;
        reset  = 1'b0;
        n      = 0;
        pulsed = 0;
        #1;
        check_all();
        repeat (3) step(1'b1);
        reset = 1'b1;
        step(1'b1);
        chk("restart_h", 32'(HORIZ), 32'd1);

        vmax = 0; fs_cnt = 0;
        for (int i = 0; i < (2 * VT + 1) * HT; i++) begin
            step(1'b1);
            if (int'(VERT) > vmax) vmax = int'(VERT);
            fs_cnt += int'(frame_start);
        end
        chk("two_frames_fs", 32'(fs_cnt), 32'd2);
`ifdef ODYSSEY_VT_FIELD_EN
        chk("long_field_vmax", 32'(vmax), 32'(VT));
        chk("field_back_to_0", 32'(field), 32'd0);
`else
        chk("frame_vmax", 32'(vmax), 32'(VT - 1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
